// File: rtl/qoi_rgb444_decoder.sv
// QOI-style RGB444 stream decoder: rebuilds pixels, the 64-entry colour index and line position.
// Optional macro QOI444_DEC_ERR_EN builds the sticky malformed-stream detector driving err.
module qoi_rgb444_decoder #(
    parameter int PIXELS_PER_LINE = 640,
    parameter int RUN_MAX         = 63
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [7:0]                           in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [11:0]                          out_rgb,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 pix_last,
    output logic [$clog2(PIXELS_PER_LINE)-1:0]   pix_idx,
    output logic                                 err
);

    localparam int IDX_W = $clog2(PIXELS_PER_LINE);
    localparam int RUN_W = $clog2(RUN_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS_PER_LINE - 1);

    localparam logic [1:0] OP_INDEX = 2'b00;
    localparam logic [1:0] OP_DIFF  = 2'b01;
    localparam logic [1:0] OP_RGB   = 2'b10;
    localparam logic [1:0] OP_RUN   = 2'b11;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_RGB2 = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Index hash; arithmetic modulo 64 keeps exactly the low 6 bits of the wider sum.
    function automatic logic [5:0] qoi_hash(input logic [11:0] px);
        return 6'd3 * {2'd0, px[11:8]} + 6'd5 * {2'd0, px[7:4]} + 6'd7 * {2'd0, px[3:0]};
    endfunction

    function automatic logic [3:0] diff_ch(input logic [3:0] p, input logic [1:0] d);
        return p + 4'd2 - {2'b00, d};
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [RUN_W-1:0]   run_cnt_r;
    logic [RUN_W-1:0]   run_next_s;
    logic [3:0]         r_hold_r;
    logic [3:0]         r_next_s;
    logic [11:0]        prev_r;
    logic [11:0]        out_rgb_r;
    logic               out_valid_r;
    logic [IDX_W-1:0]   pix_idx_r;
    logic [IDX_W-1:0]   idx_next_s;
    logic               pix_last_r;
    logic [11:0]        tbl_r [64];
    logic [11:0]        pix_s;
    logic               load_s;
    logic               tbl_wr_s;
    logic               in_ready_s;
    logic               in_fire_s;
    logic               out_fire_s;

    assign in_ready_s = (state_r != S_RUN) && (!out_valid_r || out_ready);
    assign in_fire_s  = in_valid && in_ready_s;
    assign out_fire_s = out_valid_r && out_ready;
    assign idx_next_s = (pix_idx_r == LAST_IDX) ? IDX_W'(0) : pix_idx_r + IDX_W'(1);

    // Decode the accepted byte, or advance a run, into the next pixel and next state.
    always_comb begin
        state_next_s = state_r;
        run_next_s   = run_cnt_r;
        r_next_s     = r_hold_r;
        pix_s        = prev_r;
        load_s       = 1'b0;
        tbl_wr_s     = 1'b0;
        case (state_r)
            S_OP: begin
                if (in_fire_s) begin
                    case (in_data[7:6])
                        OP_INDEX: begin
                            pix_s    = tbl_r[in_data[5:0]];
                            load_s   = 1'b1;
                            tbl_wr_s = 1'b1;
                        end
                        OP_DIFF: begin
                            pix_s    = {diff_ch(prev_r[11:8], in_data[5:4]),
                                        diff_ch(prev_r[7:4],  in_data[3:2]),
                                        diff_ch(prev_r[3:0],  in_data[1:0])};
                            load_s   = 1'b1;
                            tbl_wr_s = 1'b1;
                        end
                        OP_RGB: begin
                            r_next_s     = in_data[3:0];
                            state_next_s = S_RGB2;
                        end
                        OP_RUN: begin
                            // A zero-length run is swallowed without producing a pixel.
                            if (in_data[5:0] != 6'd0) begin
                                load_s       = 1'b1;
                                run_next_s   = RUN_W'(in_data[5:0] - 6'd1);
                                state_next_s = (in_data[5:0] == 6'd1) ? S_OP : S_RUN;
                            end else begin
                                state_next_s = S_OP;
                            end
                        end
                        default: begin
                            state_next_s = S_OP;
                        end
                    endcase
                end else begin
                    state_next_s = S_OP;
                end
            end
            S_RGB2: begin
                if (in_fire_s) begin
                    pix_s        = {r_hold_r, in_data};
                    load_s       = 1'b1;
                    tbl_wr_s     = 1'b1;
                    state_next_s = S_OP;
                end else begin
                    state_next_s = S_RGB2;
                end
            end
            S_RUN: begin
                // Leave as the final repeat is loaded so the next op byte follows with no bubble.
                if (out_fire_s) begin
                    load_s       = 1'b1;
                    run_next_s   = run_cnt_r - RUN_W'(1);
                    state_next_s = (run_cnt_r <= RUN_W'(1)) ? S_OP : S_RUN;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            default: begin
                state_next_s = S_OP;
            end
        endcase
    end

    // Control state, remaining run count and pending red nibble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_OP;
            run_cnt_r <= RUN_W'(0);
            r_hold_r  <= 4'd0;
        end else begin
            state_r   <= state_next_s;
            run_cnt_r <= run_next_s;
            r_hold_r  <= r_next_s;
        end
    end

    // Output register, previous pixel and line position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_rgb_r   <= 12'h000;
            out_valid_r <= 1'b0;
            prev_r      <= 12'h000;
            pix_idx_r   <= IDX_W'(0);
            pix_last_r  <= 1'b0;
        end else begin
            if (load_s) begin
                out_rgb_r   <= pix_s;
                out_valid_r <= 1'b1;
                prev_r      <= pix_s;
            end else if (out_fire_s) begin
                out_valid_r <= 1'b0;
            end
            if (out_fire_s) begin
                pix_idx_r  <= idx_next_s;
                pix_last_r <= (idx_next_s == LAST_IDX);
            end
        end
    end

    // Colour index table, cleared on reset and written with every non-run pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                tbl_r[i] <= 12'h000;
            end
        end else if (load_s && tbl_wr_s) begin
            tbl_r[qoi_hash(pix_s)] <= pix_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_rgb   = out_rgb_r;
    assign out_valid = out_valid_r;
    assign pix_idx   = pix_idx_r;
    assign pix_last  = pix_last_r;

`ifdef QOI444_DEC_ERR_EN
    logic [63:0] written_r;
    logic        err_r;
    logic        err_ev_s;

    // Detect zero-length runs, reads of never-written entries and nonzero RGB padding.
    always_comb begin
        err_ev_s = 1'b0;
        if (in_fire_s && (state_r == S_OP)) begin
            case (in_data[7:6])
                OP_INDEX: err_ev_s = !written_r[in_data[5:0]];
                OP_RGB:   err_ev_s = (in_data[5:4] != 2'b00);
                OP_RUN:   err_ev_s = (in_data[5:0] == 6'd0);
                default:  err_ev_s = 1'b0;
            endcase
        end else begin
            err_ev_s = 1'b0;
        end
    end

    // Written mask tracks table entries; err latches until reset, decoding is unaffected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            written_r <= 64'd0;
            err_r     <= 1'b0;
        end else begin
            if (load_s && tbl_wr_s) begin
                written_r[qoi_hash(pix_s)] <= 1'b1;
            end
            if (err_ev_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule
